// File: rtl/flag_event_reader.sv
// Rising-edge event counters for a bundle of registered status flags,
// read back one flag at a time through a clear-on-read request/response port.
module flag_event_reader #(
    parameter int N_FLAGS = 3,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = (N_FLAGS > 1) ? $clog2(N_FLAGS) : 1
) (
    input  logic               i_clk,
    input  logic               i_arst,
    input  logic [N_FLAGS-1:0] i_flags,
    input  logic               i_clr,
    input  logic               i_req_valid,
    input  logic [IDX_W-1:0]   i_req_idx,
    output logic               o_req_ready,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [CNT_W-1:0]   o_rsp_data,
    output logic               o_rsp_ovf,
    output logic               o_rsp_err,
    output logic               o_any_edge
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    // Handshake: a request transfers on a cycle where i_req_valid && o_req_ready;
    // a response transfers on a cycle where o_rsp_valid && i_rsp_ready, and the
    // response fields stay frozen while o_rsp_valid is high and i_rsp_ready is low.

    state_t             r_state;
    logic               r_primed;
    logic [N_FLAGS-1:0] r_prev;
    logic [CNT_W-1:0]   r_cnt [N_FLAGS];
    logic [N_FLAGS-1:0] r_ovf;
    logic               r_rsp_valid;
    logic [CNT_W-1:0]   r_rsp_data;
    logic               r_rsp_ovf;
    logic               r_rsp_err;
    logic               r_any_edge;

    logic [N_FLAGS-1:0] w_edge;
    logic [N_FLAGS-1:0] w_rd_vec;
    logic               w_accept;
    logic               w_hit;
    logic [CNT_W-1:0]   w_sel_cnt;
    logic               w_sel_ovf;

    assign o_req_ready = r_primed & (r_state == S_IDLE);
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_edge      = {N_FLAGS{r_primed}} & i_flags & ~r_prev;

    // Index decode doubles as the range check: no match means an error response.
    always_comb begin
        w_hit     = 1'b0;
        w_sel_cnt = '0;
        w_sel_ovf = 1'b0;
        w_rd_vec  = '0;
        for (int k = 0; k < N_FLAGS; k++) begin
            if (i_req_idx == IDX_W'(k)) begin
                w_hit       = 1'b1;
                w_sel_cnt   = r_cnt[k];
                w_sel_ovf   = r_ovf[k];
                w_rd_vec[k] = w_accept;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_primed   <= 1'b0;
            r_prev     <= '0;
            r_any_edge <= 1'b0;
        end else begin
            r_primed   <= 1'b1;
            r_prev     <= i_flags;
            r_any_edge <= |w_edge;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int k = 0; k < N_FLAGS; k++) begin
                r_cnt[k] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int k = 0; k < N_FLAGS; k++) begin
                if (i_clr) begin
                    r_cnt[k] <= '0;
                    r_ovf[k] <= 1'b0;
                end else if (w_rd_vec[k]) begin
                    // An edge coinciding with the read starts the next window.
                    r_cnt[k] <= {{(CNT_W-1){1'b0}}, w_edge[k]};
                    r_ovf[k] <= 1'b0;
                end else if (w_edge[k]) begin
                    if (&r_cnt[k]) begin
                        r_ovf[k] <= 1'b1;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_hit ? w_sel_cnt : '0;
                        r_rsp_ovf   <= w_hit & w_sel_ovf;
                        r_rsp_err   <= ~w_hit;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_ovf   = r_rsp_ovf;
    assign o_rsp_err   = r_rsp_err;
    assign o_any_edge  = r_any_edge;

endmodule

// File: tb/tb_flag_event_reader.sv
// Directed bench for flag_event_reader: an 8-bit-counter instance (a) and a
// 2-bit-counter instance (b) used for the saturation case.
module tb_flag_event_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst;
    logic [2:0] flags_a, flags_b;
    logic       clr_a, clr_b;
    logic       rv_a, rv_b;
    logic [1:0] idx_a, idx_b;
    logic       rr_a, rr_b;

    logic       qr_a, rsv_a, ro_a, re_a, ae_a;
    logic [7:0] rd_a;
    logic       qr_b, rsv_b, ro_b, re_b, ae_b;
    logic [1:0] rd_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q[$];

    flag_event_reader #(.N_FLAGS(3), .CNT_W(8)) u_dut_a (
        .i_clk(clk), .i_arst(arst), .i_flags(flags_a), .i_clr(clr_a),
        .i_req_valid(rv_a), .i_req_idx(idx_a), .o_req_ready(qr_a),
        .o_rsp_valid(rsv_a), .i_rsp_ready(rr_a), .o_rsp_data(rd_a),
        .o_rsp_ovf(ro_a), .o_rsp_err(re_a), .o_any_edge(ae_a)
    );

    flag_event_reader #(.N_FLAGS(3), .CNT_W(2)) u_dut_b (
        .i_clk(clk), .i_arst(arst), .i_flags(flags_b), .i_clr(clr_b),
        .i_req_valid(rv_b), .i_req_idx(idx_b), .o_req_ready(qr_b),
        .o_rsp_valid(rsv_b), .i_rsp_ready(rr_b), .o_rsp_data(rd_b),
        .o_rsp_ovf(ro_b), .o_rsp_err(re_b), .o_any_edge(ae_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] rsp_of(input bit b);
        if (b) return {re_b, ro_b, {6'b0, rd_b}};
        return {re_a, ro_a, rd_a};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accept a request and check the captured response one cycle later.
    task automatic issue(input bit b, input logic [1:0] idx, input logic [7:0] d,
                         input logic o, input logic e, input bit edge_en, input int edge_k);
        int n;
        n = 0;
        exp_q.push_back({e, o, d});
        while (!(b ? qr_b : qr_a) && n < 20) begin
            tick(1);
            n++;
        end
        chk("req_ready_wait", b ? qr_b : qr_a, 1);
        if (b) begin
            rv_b = 1'b1; idx_b = idx;
            if (edge_en) flags_b[edge_k] = 1'b1;
        end else begin
            rv_a = 1'b1; idx_a = idx;
            if (edge_en) flags_a[edge_k] = 1'b1;
        end
        tick(1);
        if (b) begin
            rv_b = 1'b0; idx_b = 2'($urandom_range(0, 3));
        end else begin
            rv_a = 1'b0; idx_a = 2'($urandom_range(0, 3));
        end
        chk("rsp_valid_latency", b ? rsv_b : rsv_a, 1);
        chk("rsp_fields", rsp_of(b), exp_q.pop_front());
    endtask

    task automatic finish_rsp(input bit b);
        if (b) rr_b = 1'b1; else rr_a = 1'b1;
        tick(1);
        if (b) rr_b = 1'b0; else rr_a = 1'b0;
        chk("rsp_valid_drop", b ? rsv_b : rsv_a, 0);
    endtask

    task automatic read(input bit b, input logic [1:0] idx, input logic [7:0] d,
                        input logic o, input logic e);
        issue(b, idx, d, o, e, 1'b0, 0);
        finish_rsp(b);
    endtask

    task automatic pulse(input bit b, input int k);
        if (b) flags_b[k] = 1'b1; else flags_a[k] = 1'b1;
        tick(1);
        chk("any_edge_rise", b ? ae_b : ae_a, 1);
        if (b) flags_b[k] = 1'b0; else flags_a[k] = 1'b0;
        tick(1);
        chk("any_edge_fall", b ? ae_b : ae_a, 0);
    endtask

    task automatic reset_and_prime();
        arst = 1'b1;
        flags_a = 3'b111;
        #1;
        chk("rst_req_ready", qr_a, 0);
        chk("rst_rsp_valid", rsv_a, 0);
        chk("rst_rsp_fields", rsp_of(1'b0), 10'h000);
        chk("rst_any_edge", ae_a, 0);
        chk("rst_b_req_ready", qr_b, 0);
        tick(2);
        arst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("prime_no_edge", ae_a, 0);
        end
        chk("primed_ready", qr_a, 1);
        read(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        read(1'b0, 2'd2, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        arst = 1'b1;
        flags_a = '0; flags_b = '0;
        clr_a = 1'b0; clr_b = 1'b0;
        rv_a = 1'b0; rv_b = 1'b0;
        idx_a = '0; idx_b = '0;
        rr_a = 1'b0; rr_b = 1'b0;

        // Flags high at release are not events.
        reset_and_prime();
        flags_a = 3'b000;
        tick(1);
        chk("fall_no_edge", ae_a, 0);

        // Four rising edges on flag1, then clear-on-read.
        for (int i = 0; i < 4; i++) pulse(1'b0, 1);
        read(1'b0, 2'd1, 8'd4, 1'b0, 1'b0);
        read(1'b0, 2'd1, 8'd0, 1'b0, 1'b0);

        // Saturation on the 2-bit instance.
        for (int i = 0; i < 5; i++) pulse(1'b1, 0);
        read(1'b1, 2'd0, 8'd3, 1'b1, 1'b0);
        read(1'b1, 2'd0, 8'd0, 1'b0, 1'b0);

        // Edge coinciding with accept returns the old count and starts at 1.
        pulse(1'b0, 2);
        pulse(1'b0, 2);
        issue(1'b0, 2'd2, 8'd2, 1'b0, 1'b0, 1'b1, 2);
        finish_rsp(1'b0);
        read(1'b0, 2'd2, 8'd1, 1'b0, 1'b0);
        flags_a[2] = 1'b0;

        // Clear during RESP: response holds, the edge in the clear cycle is dropped.
        for (int i = 0; i < 3; i++) pulse(1'b0, 0);
        issue(1'b0, 2'd0, 8'd3, 1'b0, 1'b0, 1'b0, 0);
        clr_a = 1'b1;
        flags_a[0] = 1'b1;
        tick(1);
        clr_a = 1'b0;
        chk("clr_hold_valid", rsv_a, 1);
        chk("clr_hold_fields", rsp_of(1'b0), {2'b00, 8'd3});
        finish_rsp(1'b0);
        read(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        flags_a[0] = 1'b0;

        // Out-of-range index, response held under backpressure.
        pulse(1'b0, 1);
        issue(1'b0, 2'd3, 8'd0, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("err_hold_valid", rsv_a, 1);
            chk("err_hold_fields", rsp_of(1'b0), {2'b10, 8'd0});
            chk("err_hold_not_ready", qr_a, 0);
        end
        finish_rsp(1'b0);
        read(1'b0, 2'd1, 8'd1, 1'b0, 1'b0);

        // Async reset in the middle of a pending response.
        pulse(1'b0, 1);
        pulse(1'b0, 1);
        issue(1'b0, 2'd1, 8'd2, 1'b0, 1'b0, 1'b0, 0);
        arst = 1'b1;
        #1;
        chk("arst_rsp_valid", rsv_a, 0);
        chk("arst_rsp_fields", rsp_of(1'b0), 10'h000);
        chk("arst_req_ready", qr_a, 0);
        reset_and_prime();
        read(1'b0, 2'd1, 8'd0, 1'b0, 1'b0);
        flags_a[0] = 1'b0;
        tick(1);
        flags_a[0] = 1'b1;
        tick(1);
        chk("reprime_edge", ae_a, 1);
        read(1'b0, 2'd0, 8'd1, 1'b0, 1'b0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
